// File: rtl/fsm_q3_frame_tx.sv
// fsm_q3_frame_tx: transmit side of the s/w majority-frame protocol.
// Buffers patterns, streams them LSB first after a one-shot start, and predicts detector z.
module fsm_q3_frame_tx #(
    parameter int FRAME_LEN   = 3,
    parameter int TARGET_ONES = 2,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [FRAME_LEN-1:0] in_pattern,
    output logic                 s,
    output logic                 w,
    output logic                 frame_start,
    output logic                 filler,
    output logic                 expect_z,
    output logic                 busy
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int BW = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
    localparam int CW = $clog2(FRAME_LEN + 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(FRAME_LEN - 1);
    localparam logic [CW-1:0] TARGET   = CW'(TARGET_ONES);
    localparam logic [AW:0]   FULL     = (AW+1)'(FIFO_DEPTH);

    // state  | meaning
    // IDLE   | nothing sent since reset, waiting for the first pattern
    // START  | one-cycle s pulse, first pattern popped
    // STREAM | continuous frames, zero filler when the buffer is empty
    typedef enum logic [1:0] {IDLE, START, STREAM} state_t;

    state_t               state;
    logic [FRAME_LEN-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]        wr_ptr;
    logic [AW-1:0]        rd_ptr;
    logic [AW:0]          count;
    logic [FRAME_LEN-1:0] frame_reg;
    logic [FRAME_LEN-1:0] head;
    logic [BW-1:0]        bit_idx;
    logic [CW-1:0]        ones;
    logic [CW-1:0]        frame_ones;
    logic                 push;
    logic                 pop;
    logic                 wrap;
    logic                 nonempty;
    logic                 cur_bit;

    assign in_ready   = (count != FULL);
    assign nonempty   = (count != '0);
    assign push       = in_valid && in_ready;
    assign head       = mem[rd_ptr];
    assign wrap       = (state == STREAM) && (bit_idx == LAST_BIT);
    assign pop        = (state == START) || (wrap && nonempty);
    assign cur_bit    = frame_reg[bit_idx];
    // Running popcount including the bit on the wire; restarts on each frame's first bit.
    assign frame_ones = ((bit_idx == '0) ? '0 : ones) + CW'(cur_bit);

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= in_pattern;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (push && !pop) begin
                count <= count + (AW+1)'(1);
            end else if (pop && !push) begin
                count <= count - (AW+1)'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            frame_reg   <= '0;
            bit_idx     <= '0;
            ones        <= '0;
            s           <= 1'b0;
            w           <= 1'b0;
            frame_start <= 1'b0;
            filler      <= 1'b0;
            expect_z    <= 1'b0;
            busy        <= 1'b0;
        end else begin
            expect_z <= wrap && (frame_ones == TARGET);
            case (state)
                IDLE: begin
                    s           <= nonempty;
                    busy        <= nonempty;
                    w           <= 1'b0;
                    frame_start <= 1'b0;
                    filler      <= 1'b0;
                    if (nonempty) begin
                        state <= START;
                    end
                end
                START: begin
                    state       <= STREAM;
                    s           <= 1'b0;
                    frame_reg   <= head;
                    filler      <= 1'b0;
                    bit_idx     <= '0;
                    w           <= head[0];
                    frame_start <= 1'b1;
                end
                STREAM: begin
                    ones <= frame_ones;
                    if (wrap) begin
                        bit_idx     <= '0;
                        frame_start <= 1'b1;
                        if (nonempty) begin
                            frame_reg <= head;
                            filler    <= 1'b0;
                            w         <= head[0];
                        end else begin
                            frame_reg <= '0;
                            filler    <= 1'b1;
                            w         <= 1'b0;
                        end
                    end else begin
                        bit_idx     <= bit_idx + BW'(1);
                        frame_start <= 1'b0;
                        w           <= frame_reg[bit_idx + BW'(1)];
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fsm_q3_frame_tx.sv
// Directed bench for fsm_q3_frame_tx plus a co-simulation against a behavioural detector.
module tb_fsm_q3_frame_tx;
    logic       clk;
    logic       reset;
    logic       in_valid;
    logic       in_ready;
    logic [2:0] in_pattern;
    logic       s;
    logic       w;
    logic       frame_start;
    logic       filler;
    logic       expect_z;
    logic       busy;

    int checks = 0;
    int errors = 0;
    int s_count = 0;

    fsm_q3_frame_tx dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_pattern  (in_pattern),
        .s           (s),
        .w           (w),
        .frame_start (frame_start),
        .filler      (filler),
        .expect_z    (expect_z),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference detector: counts ones over 3-bit windows starting the cycle after s.
    logic det_on;
    int   det_pos;
    int   det_cnt;
    logic det_z;
    always @(posedge clk) begin
        if (reset) begin
            det_on  <= 1'b0;
            det_pos <= 0;
            det_cnt <= 0;
            det_z   <= 1'b0;
        end else if (s) begin
            det_on  <= 1'b1;
            det_pos <= 0;
            det_cnt <= 0;
            det_z   <= 1'b0;
        end else if (det_on) begin
            if (det_pos == 2) begin
                det_z   <= ((det_cnt + int'(w)) == 2);
                det_pos <= 0;
                det_cnt <= 0;
            end else begin
                det_z   <= 1'b0;
                det_pos <= det_pos + 1;
                det_cnt <= det_cnt + int'(w);
            end
        end else begin
            det_z <= 1'b0;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (s === 1'b1) s_count++;
    endtask

    task automatic wait_fs(input string tag);
        int n;
        n = 0;
        do begin
            tick();
            n++;
        end while (frame_start !== 1'b1 && n < 8);
        chk(tag, frame_start, 1);
    endtask

    logic [2:0] pat2 [4];
    logic       ez2  [5];
    logic [2:0] pat3 [6];
    logic       ir3  [9];
    logic       iv4  [7];
    logic [2:0] q [$];
    logic [2:0] fbits;
    logic [2:0] pat;
    logic       rdy;
    logic       hv;
    logic       ffill;
    int         k;
    int         fpos;
    int         nframes;

    initial begin
        pat2 = '{3'b111, 3'b101, 3'b000, 3'b110};
        ez2  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        pat3 = '{3'b001, 3'b010, 3'b100, 3'b011, 3'b110, 3'b101};
        ir3  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        iv4  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};

        reset = 1'b1; in_valid = 1'b0; in_pattern = '0;
        tick(); tick();
        reset = 1'b0;
        chk("rst_s", s, 0);
        chk("rst_w", w, 0);
        chk("rst_fs", frame_start, 0);
        chk("rst_filler", filler, 0);
        chk("rst_ez", expect_z, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ready", in_ready, 1);

        // single pattern followed by filler
        in_valid = 1'b1; in_pattern = 3'b011;
        tick();
        in_valid = 1'b0;
        chk("t1_s_early", s, 0);
        tick();
        chk("t1_s", s, 1);
        chk("t1_busy", busy, 1);
        tick();
        chk("t1_fs0", frame_start, 1); chk("t1_w0", w, 1); chk("t1_s_off", s, 0);
        chk("t1_filler0", filler, 0); chk("t1_ez_first", expect_z, 0);
        tick();
        chk("t1_w1", w, 1); chk("t1_fs1", frame_start, 0);
        tick();
        chk("t1_w2", w, 0);
        tick();
        chk("t1_fill_fs", frame_start, 1); chk("t1_fill", filler, 1);
        chk("t1_fill_w", w, 0); chk("t1_ez", expect_z, 1);
        tick();
        chk("t1_ez_off", expect_z, 0); chk("t1_fill_hold", filler, 1); chk("t1_fill_w1", w, 0);

        // back-to-back pushes, contiguous frames, one s pulse
        reset = 1'b1; tick(); reset = 1'b0;
        s_count = 0;
        for (int i = 0; i < 17; i++) begin
            if (i < 4) begin
                in_valid = 1'b1; in_pattern = pat2[i];
            end else begin
                in_valid = 1'b0;
            end
            tick();
            if (i == 1) chk("t2_s", s, 1);
            if (i < 2) begin
                chk("t2_pre_fs", frame_start, 0);
            end else begin
                chk("t2_w", w, (i < 14) ? pat2[(i-2)/3][(i-2)%3] : 1'b0);
                chk("t2_fs", frame_start, ((i-2)%3 == 0) ? 1 : 0);
                if ((i-2)%3 == 0) begin
                    chk("t2_ez", expect_z, ez2[(i-2)/3]);
                    chk("t2_filler", filler, (i == 14) ? 1 : 0);
                end
            end
        end
        chk("t2_s_count", s_count, 1);

        // back-pressure with six patterns held on the input
        wait_fs("t3_sync");
        k = 0;
        for (int i = 0; i < 23; i++) begin
            if (k < 6) begin
                in_valid = 1'b1; in_pattern = pat3[k];
            end else begin
                in_valid = 1'b0;
            end
            rdy = in_ready;
            tick();
            if (k < 6 && rdy) k++;
            if (i < 9) chk("t3_ready", in_ready, ir3[i]);
            if (i >= 2) begin
                chk("t3_w", w, (i < 20) ? pat3[(i-2)/3][(i-2)%3] : 1'b0);
                if ((i-2)%3 == 0) begin
                    chk("t3_fs", frame_start, 1);
                    chk("t3_filler", filler, (i == 20) ? 1 : 0);
                end
            end
        end
        in_valid = 1'b0;
        chk("t3_accepted", k, 6);

        // push on the wrap cycle with an empty buffer
        wait_fs("t4_sync");
        tick(); tick();
        in_valid = 1'b1; in_pattern = 3'b110;
        tick();
        in_valid = 1'b0;
        chk("t4_fill_fs", frame_start, 1); chk("t4_fill", filler, 1);
        tick(); tick(); tick();
        chk("t4_data_fs", frame_start, 1); chk("t4_data", filler, 0); chk("t4_w0", w, 0);
        tick(); chk("t4_w1", w, 1);
        tick(); chk("t4_w2", w, 1);
        tick(); chk("t4_after", filler, 1); chk("t4_ez", expect_z, 1);

        // simultaneous push and pop at count 3
        for (int i = 0; i < 7; i++) begin
            in_valid = iv4[i]; in_pattern = 3'(i);
            tick();
            if (i == 4) chk("t4_ready_c3", in_ready, 1);
            if (i == 5) chk("t4_ready_pp", in_ready, 1);
            if (i == 6) chk("t4_ready_full", in_ready, 0);
        end
        in_valid = 1'b0;

        // reset mid-frame with two patterns queued
        reset = 1'b1; tick(); reset = 1'b0;
        in_valid = 1'b1; in_pattern = 3'b011; tick();
        in_pattern = 3'b101; tick();
        in_pattern = 3'b110; tick();
        in_valid = 1'b0;
        chk("t5_fs", frame_start, 1);
        tick();
        chk("t5_mid_w", w, 1); chk("t5_mid_fs", frame_start, 0);
        reset = 1'b1; tick(); reset = 1'b0;
        chk("t5_s", s, 0); chk("t5_w", w, 0); chk("t5_fs_r", frame_start, 0);
        chk("t5_filler", filler, 0); chk("t5_ez", expect_z, 0); chk("t5_busy", busy, 0);
        chk("t5_ready", in_ready, 1);
        tick(); tick();
        chk("t5_flushed_busy", busy, 0); chk("t5_flushed_s", s, 0);
        in_valid = 1'b1; in_pattern = 3'b100; tick();
        in_valid = 1'b0;
        chk("t5_s_early", s, 0);
        tick(); chk("t5_s_new", s, 1);
        tick(); chk("t5_new_fs", frame_start, 1); chk("t5_new_w0", w, 0);
        tick(); chk("t5_new_w1", w, 0);
        tick(); chk("t5_new_w2", w, 1);

        // random co-simulation against the detector model
        reset = 1'b1; tick(); reset = 1'b0;
        fpos = 3; nframes = 0; ffill = 1'b0; fbits = '0;
        for (int c = 0; c < 1520; c++) begin
            in_valid = ($urandom_range(0, 2) == 0);
            pat = 3'($urandom_range(0, 7));
            in_pattern = pat;
            rdy = in_ready; hv = in_valid;
            tick();
            if (hv && rdy) q.push_back(pat);
            chk("cosim_z", expect_z, det_z);
            if (frame_start) begin
                fpos = 0; ffill = filler; nframes++;
            end
            if (fpos < 3) begin
                fbits[fpos] = w;
                fpos++;
                if (fpos == 3 && !ffill) begin
                    chk("cosim_queue", (q.size() > 0) ? 1 : 0, 1);
                    if (q.size() > 0) chk("cosim_data", fbits, q.pop_front());
                end
            end
        end
        in_valid = 1'b0;
        chk("cosim_frames", (nframes >= 500) ? 1 : 0, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
